// File: rtl/adc1bit_gearbox_packer.sv
// ============================================================================
// adc1bit_gearbox_packer
//
// Collects NUM_CH comparator bits per valid sample into one continuous bit
// stream and repacks that stream into WORD_W-bit words. Bits left over after
// a word completes start the next word. Completed words go into a
// DEPTH-entry first-word-fall-through queue with a valid/ready output.
//
// An explicit flush zero-pads the partial word and tags it as the last word.
// Bit order inside the output word is selectable. Words that find the queue
// full are dropped and counted.
//
// Ports
//   adc_clk_i     in   clock for all logic
//   rst_n         in   asynchronous active-low reset
//   clear_i       in   synchronous clear, same effect as reset, dominant
//   valid_i       in   ch_data_i carries a sample this cycle
//   ch_data_i     in   NUM_CH sample bits, bit 0 is first in stream order
//   flush_i       in   pad and emit the partial word (pulse)
//   word_ready_i  in   downstream takes the head word this cycle
//   word_valid_o  out  queue head valid
//   word_data_o   out  queue head data (zero when empty)
//   word_last_o   out  head word was closed by a flush (zero when empty)
//   fill_cnt_o    out  number of words in the queue
//   full_o        out  queue holds DEPTH words
//   empty_o       out  queue holds no word
//   ovf_o         out  sticky flag, at least one word was dropped
//   ovf_cnt_o     out  dropped word count, saturating
// ============================================================================
module adc1bit_gearbox_packer #(
    parameter int NUM_CH    = 17,
    parameter int WORD_W    = 256,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                         adc_clk_i,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         valid_i,
    input  logic [NUM_CH-1:0]            ch_data_i,
    input  logic                         flush_i,
    input  logic                         word_ready_i,
    output logic                         word_valid_o,
    output logic [WORD_W-1:0]            word_data_o,
    output logic                         word_last_o,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         ovf_o,
    output logic [15:0]                  ovf_cnt_o
);

    localparam int CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int EXT_W  = WORD_W + NUM_CH;

    localparam logic [CNT_W:0]    WORD_W_L = (CNT_W + 1)'(WORD_W);
    localparam logic [CNT_W:0]    NUM_CH_L = (CNT_W + 1)'(NUM_CH);
    localparam logic [FILL_W-1:0] DEPTH_L  = FILL_W'(DEPTH);

    // Maps a word held in stream order onto the output bit order.
    function automatic logic [WORD_W-1:0] order_word(input logic [WORD_W-1:0] stream_w);
        logic [WORD_W-1:0] res;
        res = stream_w;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WORD_W; i++) begin
                res[i] = stream_w[WORD_W-1-i];
            end
        end else begin
            res = stream_w;
        end
        return res;
    endfunction

    // Gearbox state: partial word in stream order; bits at and above acc_cnt are always zero.
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic              flush_pend_q, flush_pend_d;

    // Queue state: entry 0 is the head, so the outputs come straight from flops.
    logic [WORD_W:0]   q_q [DEPTH];
    logic [WORD_W:0]   q_d [DEPTH];
    logic [FILL_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       ovf_cnt_q, ovf_cnt_d;

    logic [EXT_W-1:0]  sample_ext_s;
    logic [EXT_W-1:0]  ext_s;
    logic [CNT_W:0]    sum_s;
    logic              push_s;
    logic [WORD_W:0]   push_entry_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              drop_s;
    logic [FILL_W-1:0] cnt_pop_s;

    // Gearbox: merge the sample at acc_cnt, split off completed or flushed words.
    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        push_s       = 1'b0;
        push_entry_s = '0;
        sample_ext_s = EXT_W'(ch_data_i) << acc_cnt_q;
        ext_s        = EXT_W'(acc_q) | sample_ext_s;
        sum_s        = {1'b0, acc_cnt_q} + NUM_CH_L;

        if (valid_i) begin
            // A flush seen together with a sample waits for the first idle cycle.
            if (flush_i || flush_pend_q) begin
                flush_pend_d = 1'b1;
            end else begin
                flush_pend_d = flush_pend_q;
            end
            if (sum_s >= WORD_W_L) begin
                push_s       = 1'b1;
                push_entry_s = {1'b0, order_word(ext_s[WORD_W-1:0])};
                // Bits spilling past the word boundary open the next word.
                acc_d        = WORD_W'(ext_s >> WORD_W);
                acc_cnt_d    = CNT_W'(sum_s - WORD_W_L);
            end else begin
                acc_d        = ext_s[WORD_W-1:0];
                acc_cnt_d    = CNT_W'(sum_s);
            end
        end else if (flush_i || flush_pend_q) begin
            flush_pend_d = 1'b0;
            if (acc_cnt_q != '0) begin
                push_s       = 1'b1;
                push_entry_s = {1'b1, order_word(acc_q)};
                acc_d        = '0;
                acc_cnt_d    = '0;
            end else begin
                acc_d        = acc_q;
                acc_cnt_d    = acc_cnt_q;
            end
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    // Queue: pop shifts every entry toward the head, then a push lands behind the last word.
    always_comb begin
        pop_s     = valid_q & word_ready_i;
        push_ok_s = push_s & ((cnt_q != DEPTH_L) | pop_s);
        drop_s    = push_s & ~push_ok_s;

        if (pop_s) begin
            cnt_pop_s = cnt_q - FILL_W'(1);
        end else begin
            cnt_pop_s = cnt_q;
        end

        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop_s) begin
                q_d[i] = q_q[i+1];
            end else begin
                q_d[i] = q_q[i];
            end
        end
        if (pop_s) begin
            q_d[DEPTH-1] = '0;
        end else begin
            q_d[DEPTH-1] = q_q[DEPTH-1];
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok_s && (FILL_W'(i) == cnt_pop_s)) begin
                q_d[i] = push_entry_s;
            end else begin
                q_d[i] = q_d[i];
            end
        end

        cnt_d   = cnt_pop_s + FILL_W'(push_ok_s);
        valid_d = (cnt_d != '0);
        full_d  = (cnt_d == DEPTH_L);
        empty_d = (cnt_d == '0);

        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (drop_s) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with async reset and dominant synchronous clear.
    always_ff @(posedge adc_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 1'b0;
            ovf_cnt_q    <= 16'h0000;
        end else if (clear_i) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 1'b0;
            ovf_cnt_q    <= 16'h0000;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            ovf_q        <= ovf_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign word_valid_o = valid_q;
    assign word_data_o  = q_q[0][WORD_W-1:0];
    assign word_last_o  = q_q[0][WORD_W];
    assign fill_cnt_o   = cnt_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign ovf_o        = ovf_q;
    assign ovf_cnt_o    = ovf_cnt_q;

endmodule

// File: tb/tb_adc1bit_gearbox_packer.sv
// ============================================================================
// tb_adc1bit_gearbox_packer
//
// Drives an LSB-first and an MSB-first instance with identical stimulus and
// compares both every cycle against a bit-queue reference model.
// ============================================================================
module tb_adc1bit_gearbox_packer;

    localparam int NUM_CH = 17;
    localparam int WORD_W = 256;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              clear_i;
    logic              valid_i;
    logic [NUM_CH-1:0] ch_data_i;
    logic              flush_i;
    logic              word_ready_i;

    logic              valid_a, valid_b;
    logic [WORD_W-1:0] data_a, data_b;
    logic              last_a, last_b;
    logic [2:0]        fill_a, fill_b;
    logic              full_a, full_b;
    logic              empty_a, empty_b;
    logic              ovf_a, ovf_b;
    logic [15:0]       ovfc_a, ovfc_b;

    int n_checks = 0;
    int n_fail   = 0;

    adc1bit_gearbox_packer #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_lsb (
        .adc_clk_i(clk), .rst_n(rst_n), .clear_i(clear_i), .valid_i(valid_i),
        .ch_data_i(ch_data_i), .flush_i(flush_i), .word_ready_i(word_ready_i),
        .word_valid_o(valid_a), .word_data_o(data_a), .word_last_o(last_a),
        .fill_cnt_o(fill_a), .full_o(full_a), .empty_o(empty_a),
        .ovf_o(ovf_a), .ovf_cnt_o(ovfc_a)
    );

    adc1bit_gearbox_packer #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_msb (
        .adc_clk_i(clk), .rst_n(rst_n), .clear_i(clear_i), .valid_i(valid_i),
        .ch_data_i(ch_data_i), .flush_i(flush_i), .word_ready_i(word_ready_i),
        .word_valid_o(valid_b), .word_data_o(data_b), .word_last_o(last_b),
        .fill_cnt_o(fill_b), .full_o(full_b), .empty_o(empty_b),
        .ovf_o(ovf_b), .ovf_cnt_o(ovfc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stream as a bit queue, output queue of {last, word}.
    bit              bits_m[$];
    logic [WORD_W:0] oq_m[$];
    bit              pend_m;
    bit              ovf_m;
    int              ovfc_m;

    task automatic check_val(input string tag, input logic [WORD_W:0] got, input logic [WORD_W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        bits_m.delete();
        oq_m.delete();
        pend_m = 1'b0;
        ovf_m  = 1'b0;
        ovfc_m = 0;
    endtask

    task automatic model_step(input bit v, input logic [NUM_CH-1:0] d, input bit f, input bit r, input bit c);
        logic [WORD_W-1:0] w;
        logic [WORD_W:0]   entry;
        bit                have;
        if (c) begin
            model_reset();
            return;
        end
        have  = 1'b0;
        entry = '0;
        if (v) begin
            for (int i = 0; i < NUM_CH; i++) bits_m.push_back(d[i]);
            if (bits_m.size() >= WORD_W) begin
                w = '0;
                for (int i = 0; i < WORD_W; i++) w[i] = bits_m.pop_front();
                entry = {1'b0, w};
                have  = 1'b1;
            end
            if (f || pend_m) pend_m = 1'b1;
        end else if (f || pend_m) begin
            pend_m = 1'b0;
            if (bits_m.size() > 0) begin
                w = '0;
                for (int i = 0; i < bits_m.size(); i++) w[i] = bits_m[i];
                bits_m.delete();
                entry = {1'b1, w};
                have  = 1'b1;
            end
        end
        if (oq_m.size() > 0 && r) void'(oq_m.pop_front());
        if (have) begin
            if (oq_m.size() < DEPTH) begin
                oq_m.push_back(entry);
            end else begin
                ovf_m = 1'b1;
                if (ovfc_m < 65535) ovfc_m++;
            end
        end
    endtask

    function automatic logic [WORD_W-1:0] rev_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] res;
        for (int i = 0; i < WORD_W; i++) res[i] = w[WORD_W-1-i];
        return res;
    endfunction

    task automatic check_outputs();
        logic [WORD_W-1:0] ew;
        logic              el;
        int                sz;
        sz = oq_m.size();
        ew = (sz > 0) ? oq_m[0][WORD_W-1:0] : '0;
        el = (sz > 0) ? oq_m[0][WORD_W] : 1'b0;
        check_val("valid",     257'(valid_a), 257'(sz > 0));
        check_val("data",      257'(data_a),  257'(ew));
        check_val("last",      257'(last_a),  257'(el));
        check_val("fill",      257'(fill_a),  257'(sz));
        check_val("full",      257'(full_a),  257'(sz == DEPTH));
        check_val("empty",     257'(empty_a), 257'(sz == 0));
        check_val("ovf",       257'(ovf_a),   257'(ovf_m));
        check_val("ovf_cnt",   257'(ovfc_a),  257'(ovfc_m));
        check_val("msb_valid", 257'(valid_b), 257'(sz > 0));
        check_val("msb_data",  257'(data_b),  257'(rev_word(ew)));
        check_val("msb_last",  257'(last_b),  257'(el));
        check_val("msb_ovfc",  257'(ovfc_b),  257'(ovfc_m));
    endtask

    task automatic step(input bit v, input logic [NUM_CH-1:0] d, input bit f, input bit r, input bit c);
        valid_i      = v;
        ch_data_i    = d;
        flush_i      = f;
        word_ready_i = r;
        clear_i      = c;
        @(posedge clk);
        model_step(v, d, f, r, c);
        #1;
        check_outputs();
    endtask

    logic [WORD_W-1:0] k_w;
    logic [NUM_CH-1:0] rd;

    initial begin
        rst_n = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ch_data_i = '0;
        flush_i = 1'b0; word_ready_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check_outputs();

        // Test 1: 16 all-ones samples make one all-ones word.
        for (int i = 0; i < 16; i++) step(1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b0);
        k_w = '1;
        check_val("t1_word", {last_a, data_a}, {1'b0, k_w});
        check_val("t1_valid", 257'(valid_a), 257'(1'b1));

        // Test 2: flush emits the 16 leftover ones, last set.
        step(1'b0, 17'h00000, 1'b1, 1'b1, 1'b0);
        k_w = 256'h0000_FFFF;
        check_val("t2_word", {last_a, data_a}, {1'b1, k_w});
        step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0);

        // Test 3: overflow with ready low, then drain and clear.
        step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 76; i++) begin
            rd = 17'($urandom());
            step(1'b1, rd, 1'b0, 1'b0, 1'b0);
        end
        check_val("t3_fill", 257'(fill_a), 257'(3'd4));
        check_val("t3_full", 257'(full_a), 257'(1'b1));
        check_val("t3_ovf", 257'(ovf_a), 257'(1'b1));
        check_val("t3_ovfc", 257'(ovfc_a), 257'(16'd1));
        for (int i = 0; i < 4; i++) step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0);
        check_val("t3_empty", 257'(empty_a), 257'(1'b1));
        step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b1);
        check_val("t3_clr_ovfc", 257'(ovfc_a), 257'(16'd0));

        // Test 4: single sample then flush, bit order on both instances.
        step(1'b1, 17'h00001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 17'h00000, 1'b1, 1'b0, 1'b0);
        k_w = '0; k_w[255] = 1'b1;
        check_val("t4_msb", {last_b, data_b}, {1'b1, k_w});
        k_w = '0; k_w[0] = 1'b1;
        check_val("t4_lsb", {last_a, data_a}, {1'b1, k_w});
        step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b1);

        // Test 5: flush held with valid for 3 cycles defers to the idle cycle.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 17'h1FFFF, 1'b1, 1'b1, 1'b0);
            check_val("t5_wait", 257'(valid_a), 257'(1'b0));
        end
        step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0);
        k_w = '0;
        for (int i = 0; i < 51; i++) k_w[i] = 1'b1;
        check_val("t5_word", {last_a, data_a}, {1'b1, k_w});
        step(1'b0, 17'h00000, 1'b0, 1'b1, 1'b0);
        check_val("t5_once", 257'(valid_a), 257'(1'b0));

        // Test 6: async reset with two words queued.
        for (int i = 0; i < 31; i++) step(1'b1, 17'($urandom()), 1'b0, 1'b0, 1'b0);
        check_val("t6_fill", 257'(fill_a), 257'(3'd2));
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        valid_i = 1'b0; flush_i = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b0);
        k_w = '1;
        check_val("t6_word", {last_a, data_a}, {1'b0, k_w});

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7, 17'($urandom()), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
